// File: rtl/riscv_div_sequencer.sv
// Issue/retire sequencer between execute and the iterative 64-bit divider.
// Optional one-entry result cache: define RISCV_DIV_SEQ_CACHE_EN.
module riscv_div_sequencer (
  input  logic        i_riscv_divseq_clk,
  input  logic        i_riscv_divseq_rst_n,
  input  logic        i_riscv_divseq_valid,
  input  logic [3:0]  i_riscv_divseq_divctrl,
  input  logic [63:0] i_riscv_divseq_rs1data,
  input  logic [63:0] i_riscv_divseq_rs2data,
  input  logic [4:0]  i_riscv_divseq_rdaddr,
  input  logic        i_riscv_divseq_flush,
  output logic [3:0]  o_riscv_divseq_div_divctrl,
  output logic [63:0] o_riscv_divseq_div_rs1data,
  output logic [63:0] o_riscv_divseq_div_rs2data,
  input  logic [63:0] i_riscv_divseq_div_result,
  input  logic        i_riscv_divseq_div_valid,
  output logic        o_riscv_divseq_stall,
  output logic        o_riscv_divseq_busy,
  output logic        o_riscv_divseq_wb_valid,
  output logic [63:0] o_riscv_divseq_result,
  output logic [4:0]  o_riscv_divseq_rdaddr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  divctrl_q, divctrl_d;
  logic [63:0] rs1_q, rs1_d;
  logic [63:0] rs2_q, rs2_d;
  logic [4:0]  rd_pend_q, rd_pend_d;
  logic [63:0] result_q, result_d;
  logic [4:0]  rdaddr_q, rdaddr_d;

  logic        req;
  logic        cache_hit;
  logic [63:0] cache_result;

  assign req = i_riscv_divseq_valid & i_riscv_divseq_divctrl[3] & ~i_riscv_divseq_flush;

`ifdef RISCV_DIV_SEQ_CACHE_EN
  logic        c_valid_q, c_valid_d;
  logic [3:0]  c_ctrl_q, c_ctrl_d;
  logic [63:0] c_rs1_q, c_rs1_d;
  logic [63:0] c_rs2_q, c_rs2_d;
  logic [63:0] c_res_q, c_res_d;

  assign cache_hit = c_valid_q
                   && (c_ctrl_q == i_riscv_divseq_divctrl)
                   && (c_rs1_q  == i_riscv_divseq_rs1data)
                   && (c_rs2_q  == i_riscv_divseq_rs2data);
  assign cache_result = c_res_q;

  // Key comes from the held divider operands, so drained runs are cached too.
  always_comb begin
    c_valid_d = c_valid_q;
    c_ctrl_d  = c_ctrl_q;
    c_rs1_d   = c_rs1_q;
    c_rs2_d   = c_rs2_q;
    c_res_d   = c_res_q;
    if (i_riscv_divseq_div_valid && ((state_q == S_RUN) || (state_q == S_DRAIN))) begin
      c_valid_d = 1'b1;
      c_ctrl_d  = divctrl_q;
      c_rs1_d   = rs1_q;
      c_rs2_d   = rs2_q;
      c_res_d   = i_riscv_divseq_div_result;
    end
  end

  always_ff @(posedge i_riscv_divseq_clk or negedge i_riscv_divseq_rst_n) begin
    if (!i_riscv_divseq_rst_n) begin
      c_valid_q <= 1'b0;
      c_ctrl_q  <= '0;
      c_rs1_q   <= '0;
      c_rs2_q   <= '0;
      c_res_q   <= '0;
    end else begin
      c_valid_q <= c_valid_d;
      c_ctrl_q  <= c_ctrl_d;
      c_rs1_q   <= c_rs1_d;
      c_rs2_q   <= c_rs2_d;
      c_res_q   <= c_res_d;
    end
  end
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  always_comb begin
    state_d   = state_q;
    divctrl_d = divctrl_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_pend_d = rd_pend_q;
    result_d  = result_q;
    rdaddr_d  = rdaddr_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (cache_hit) begin
            state_d  = S_DONE;
            result_d = cache_result;
            rdaddr_d = i_riscv_divseq_rdaddr;
          end else begin
            state_d   = S_RUN;
            divctrl_d = i_riscv_divseq_divctrl;
            rs1_d     = i_riscv_divseq_rs1data;
            rs2_d     = i_riscv_divseq_rs2data;
            rd_pend_d = i_riscv_divseq_rdaddr;
          end
        end
      end
      S_RUN: begin
        // Flush outranks a same-cycle completion: the result is dropped.
        if (i_riscv_divseq_flush) begin
          if (i_riscv_divseq_div_valid) begin
            state_d   = S_IDLE;
            divctrl_d = '0;
            rs1_d     = '0;
            rs2_d     = '0;
            rd_pend_d = '0;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (i_riscv_divseq_div_valid) begin
          state_d   = S_DONE;
          result_d  = i_riscv_divseq_div_result;
          rdaddr_d  = rd_pend_q;
          divctrl_d = '0;
          rs1_d     = '0;
          rs2_d     = '0;
          rd_pend_d = '0;
        end
      end
      S_DRAIN: begin
        if (i_riscv_divseq_div_valid) begin
          state_d   = S_IDLE;
          divctrl_d = '0;
          rs1_d     = '0;
          rs2_d     = '0;
          rd_pend_d = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_riscv_divseq_clk or negedge i_riscv_divseq_rst_n) begin
    if (!i_riscv_divseq_rst_n) begin
      state_q   <= S_IDLE;
      divctrl_q <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_pend_q <= '0;
      result_q  <= '0;
      rdaddr_q  <= '0;
    end else begin
      state_q   <= state_d;
      divctrl_q <= divctrl_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_pend_q <= rd_pend_d;
      result_q  <= result_d;
      rdaddr_q  <= rdaddr_d;
    end
  end

  assign o_riscv_divseq_div_divctrl = divctrl_q;
  assign o_riscv_divseq_div_rs1data = rs1_q;
  assign o_riscv_divseq_div_rs2data = rs2_q;
  assign o_riscv_divseq_stall       = req & (state_q != S_DONE);
  assign o_riscv_divseq_busy        = (state_q != S_IDLE);
  assign o_riscv_divseq_wb_valid    = (state_q == S_DONE);
  assign o_riscv_divseq_result      = result_q;
  assign o_riscv_divseq_rdaddr      = rdaddr_q;

endmodule
